// File: rtl/ps2_keypad_if.sv
// Bundle of the PS/2 pins and the decoded keypad outputs.
// The keypad receiver uses the slave view; whatever drives the pins uses master.
interface ps2_keypad_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [9:0] keyinput;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keyinput,
        input  code,
        input  code_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keyinput,
        output code,
        output code_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_keypad.sv
// PS/2 keyboard receiver and GBA keypad mapper.
// Samples the raw PS/2 pins, assembles 11-bit frames with odd parity,
// tracks the E0/F0 prefixes and maintains an active-low KEYINPUT vector.
module ps2_keypad #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_keypad_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BRK = 8'hF0;

    // Scan codes per KEYINPUT bit, bit 0 in the low byte:
    // L, R, Down, Up, Left, Right, Start, Select, B, A
    localparam logic [79:0] KEY_CODES = {
        8'h3C, 8'h44, 8'h72, 8'h75, 8'h6B, 8'h74, 8'h5A, 8'h66, 8'h3B, 8'h42
    };
    // Which keys need the E0 prefix (the four arrows)
    localparam logic [9:0] KEY_EXT = 10'b00_1111_0000;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchronizers; idle bus level is high
    logic clk_s1_reg, clk_s2_reg, clk_prev_reg;
    logic dat_s1_reg, dat_s2_reg;
    logic fall;

    state_t        state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_reg, parity_next;
    logic [CW-1:0] tmo_reg, tmo_next;
    logic [7:0]    code_reg, code_next;
    logic          code_valid_reg, code_valid_next;
    logic          frame_err_reg, frame_err_next;

    logic          ext_reg, brk_reg;
    logic [9:0]    key_reg;
    logic [9:0]    hit;
    logic          is_prefix;

    // Two-flop synchronizers plus the previous clock sample for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1_reg   <= 1'b1;
            clk_s2_reg   <= 1'b1;
            clk_prev_reg <= 1'b1;
            dat_s1_reg   <= 1'b1;
            dat_s2_reg   <= 1'b1;
        end else begin
            clk_s1_reg   <= bus.ps2_clk;
            clk_s2_reg   <= clk_s1_reg;
            clk_prev_reg <= clk_s2_reg;
            dat_s1_reg   <= bus.ps2_data;
            dat_s2_reg   <= dat_s1_reg;
        end
    end

    assign fall = clk_prev_reg & ~clk_s2_reg;

    // Frame FSM state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            parity_reg     <= 1'b0;
            tmo_reg        <= '0;
            code_reg       <= 8'h00;
            code_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            parity_reg     <= parity_next;
            tmo_reg        <= tmo_next;
            code_reg       <= code_next;
            code_valid_reg <= code_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // Next-state logic: bit assembly on each falling edge, checks at stop, timeout
    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        parity_next     = parity_reg;
        tmo_next        = tmo_reg;
        code_next       = code_reg;
        code_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        // Idle-time counter: only runs mid-frame, saturates at its last value
        if (state_reg == IDLE || fall) begin
            tmo_next = '0;
        end else if (tmo_reg != TMO_LAST) begin
            tmo_next = tmo_reg + 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (fall && !dat_s2_reg) begin
                    state_next   = DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_next   = {dat_s2_reg, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_next = dat_s2_reg;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    if (dat_s2_reg && ((^shift_reg) ^ parity_reg)) begin
                        code_next       = shift_reg;
                        code_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A stalled frame is abandoned; a falling edge in the same cycle wins
        if (state_reg != IDLE && !fall && tmo_reg == TMO_LAST) begin
            state_next     = IDLE;
            frame_err_next = 1'b1;
        end
    end

    // Per-key match against the scan code table
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_key_match
            assign hit[gi] = (code_reg == KEY_CODES[gi*8 +: 8]) &&
                             (ext_reg == KEY_EXT[gi]);
        end
    endgenerate

    assign is_prefix = (code_reg == CODE_EXT) || (code_reg == CODE_BRK);

    // Prefix flags: set by E0/F0, cleared by any other byte or a bad frame
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (frame_err_reg) begin
            ext_reg <= 1'b0;
            brk_reg <= 1'b0;
        end else if (code_valid_reg) begin
            if (code_reg == CODE_EXT) begin
                ext_reg <= 1'b1;
            end else if (code_reg == CODE_BRK) begin
                brk_reg <= 1'b1;
            end else begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end
        end
    end

    // Key state: a matched key takes the break flag (1 = released), others hold
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg <= 10'h3FF;
        end else if (code_valid_reg && !is_prefix) begin
            for (int i = 0; i < 10; i++) begin
                if (hit[i]) begin
                    key_reg[i] <= brk_reg;
                end
            end
        end
    end

    assign bus.keyinput   = key_reg;
    assign bus.code       = code_reg;
    assign bus.code_valid = code_valid_reg;
    assign bus.frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ps2_keypad.sv
// Testbench for ps2_keypad: drives PS/2 frames on the pins and checks every
// code_valid / frame_err pulse and the resulting keyinput against a scoreboard.
`timescale 1ns/1ps
module tb_ps2_keypad;

    localparam int TMO  = 300;  // short timeout keeps the run small
    localparam int HALF = 20;   // half PS/2 bit period in clk cycles

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic [9:0] key;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   err_count;
    int   err_cyc;
    int   last_fall;
    exp_t q[$];

    ps2_keypad_if bus ();

    ps2_keypad #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one PS/2 bit: data set while clock high, then a low half-period
    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.ps2_data = b;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fr[i]);
        @(negedge clk);
        bus.ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [9:0] exp_key);
        q.push_back('{is_err: 1'b0, code: b, key: exp_key});
        send_frame(b, 1'b0, 11);
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("drain", q.size(), 0);
    endtask

    // Output monitor: one line per transaction, compared against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.code_valid || bus.frame_err)) begin
                chk("excl", {30'd0, bus.code_valid, bus.frame_err} == 32'd3, 0);
                if (q.size() == 0) begin
                    chk("unexp_pulse", {30'd0, bus.code_valid, bus.frame_err}, 0);
                end else begin
                    e = q.pop_front();
                    if (bus.frame_err) begin
                        err_count++;
                        err_cyc = cyc;
                    end
                    chk("kind", bus.frame_err, e.is_err);
                    if (!e.is_err) chk("code", bus.code, e.code);
                    @(negedge clk);
                    chk("key", bus.keyinput, e.key);
                    $display("txn err=%0b code=%02h keyinput=%03h", e.is_err, bus.code, bus.keyinput);
                end
            end
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_errors = 0; err_count = 0; err_cyc = 0; last_fall = 0; cyc = 0;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_key", bus.keyinput, 10'h3FF);
        chk("rst_code", bus.code, 8'h00);
        chk("rst_cv", bus.code_valid, 0);
        chk("rst_fe", bus.frame_err, 0);

        // Make, then break of A
        send_byte(8'h42, 10'h3FE);
        send_byte(8'hF0, 10'h3FE);
        send_byte(8'h42, 10'h3FF);
        drain(2000);

        // Extended arrows: Up, Right while Up held, release Up
        send_byte(8'hE0, 10'h3FF);
        send_byte(8'h75, 10'h3BF);
        send_byte(8'hE0, 10'h3BF);
        send_byte(8'h74, 10'h3AF);
        send_byte(8'hE0, 10'h3AF);
        send_byte(8'hF0, 10'h3AF);
        send_byte(8'h75, 10'h3EF);
        drain(2000);

        // Parity error, then a good B
        q.push_back('{is_err: 1'b1, code: 8'h00, key: 10'h3EF});
        send_frame(8'h42, 1'b1, 11);
        send_byte(8'h3B, 10'h3ED);
        drain(2000);
        chk("err_cnt_par", err_count, 1);

        // Abandoned frame after start + 5 data bits
        q.push_back('{is_err: 1'b1, code: 8'h00, key: 10'h3ED});
        send_frame(8'h42, 1'b0, 6);
        drain(TMO + 200);
        chk("tmo_cycle", err_cyc, last_fall + 3 + TMO);
        repeat (TMO) @(negedge clk);
        chk("err_cnt_tmo", err_count, 2);
        send_byte(8'h5A, 10'h3E5);
        drain(2000);

        // Unmapped codes leave keys alone
        send_byte(8'hE0, 10'h3E5);
        send_byte(8'h12, 10'h3E5);
        send_byte(8'hAA, 10'h3E5);
        send_byte(8'hF0, 10'h3E5);
        drain(2000);

        // Reset between F0 and 42 discards the break flag
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_key", bus.keyinput, 10'h3FF);
        send_byte(8'h42, 10'h3FE);
        drain(2000);
        chk("err_cnt_end", err_count, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
